montador_jogada_16: RTL and testbench

Upstream stage of the 16-bit play register: collects four key presses from the 4-bit button bus, packs them as four nibbles into a 16-bit word, and drives that register's data input and enable. One press-and-release cycle yields one nibble; after the fourth release it emits a single-cycle `registra` pulse so the downstream register captures the complete word. An optional inactivity timeout aborts an incomplete entry.

---
 rtl/montador_jogada_16_pkg.sv | 11 +
 rtl/montador_jogada_16_contador_timeout.sv | 16 +
 rtl/montador_jogada_16.sv | 67 ++++++
 tb/tb_montador_jogada_16.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/montador_jogada_16_pkg.sv
// montador_jogada_16_pkg: shared state encoding and sizes for the play-word assembler
package montador_jogada_16_pkg;
  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    ESPERA  = 2'b01,
    SOLTA   = 2'b10,
    CONCLUI = 2'b11
  } estado_t;
  localparam int DIGITOS      = 4;
  localparam int LARGURA_DADO = 16;
endpackage

// File: rtl/montador_jogada_16_contador_timeout.sv
// contador_timeout: up-counter with sync clear/enable that parks at MODULO-1 and flags it
module contador_timeout #(
  parameter int MODULO = 5000
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic fim
);
  localparam int W = $clog2(MODULO + 1);
  logic [W-1:0] valor;
  assign fim = valor == W'(MODULO - 1);
  always_ff @(posedge clock)
    if (clear) valor <= '0;
    else if (enable && !fim) valor <= valor + W'(1);
endmodule

// File: rtl/montador_jogada_16.sv
// montador_jogada_16: packs four key presses into a 16-bit word and pulses registra when complete.
// Optional inactivity abort in ESPERA is enabled by defining MONTADOR_TIMEOUT_EN.
module montador_jogada_16
  import montador_jogada_16_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    iniciar,
  input  logic [3:0]              botoes,
  output logic [LARGURA_DADO-1:0] dado,
  output logic                    registra,
  output logic                    ocupado,
  output logic [1:0]              digito,
  output logic                    timeout
);
  estado_t estado, proximo;
  logic [$clog2(DIGITOS)-1:0] conta;
  logic pressiona, aborta, zera, fim;
  if (TIMEOUT_CYCLES < 1) begin : g_param_invalido
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef MONTADOR_TIMEOUT_EN
  // Held in clear outside ESPERA, so SOLTA time is never counted and every ESPERA entry starts at zero
  contador_timeout #(.MODULO(TIMEOUT_CYCLES)) u_timeout (
    .clock (clock),
    .clear (clear || estado != ESPERA),
    .enable(estado == ESPERA),
    .fim   (fim)
  );
`else
  assign fim = 1'b0;
`endif
  assign digito = conta;
  always_comb begin
    pressiona = estado == ESPERA && botoes != 4'd0;
    aborta    = estado == ESPERA && botoes == 4'd0 && fim;
    zera      = (estado == INICIAL && iniciar) || aborta;
    registra  = estado == CONCLUI;
    ocupado   = estado != INICIAL;
    proximo   = estado;
    case (estado)
      INICIAL: proximo = iniciar ? ESPERA : INICIAL;
      ESPERA:  proximo = pressiona ? SOLTA : aborta ? INICIAL : ESPERA;
      SOLTA:   proximo = botoes != 4'd0 ? SOLTA : conta == '0 ? CONCLUI : ESPERA;
      default: proximo = INICIAL;
    endcase
  end
  always_ff @(posedge clock)
    if (clear) begin
      estado  <= INICIAL;
      dado    <= '0;
      conta   <= '0;
      timeout <= 1'b0;
    end else begin
      estado  <= proximo;
      timeout <= aborta;
      if (zera) begin
        dado  <= '0;
        conta <= '0;
      end else if (pressiona) begin
        dado  <= {dado[LARGURA_DADO-5:0], botoes};
        conta <= conta + 1'b1;
      end
    end
endmodule

// File: tb/tb_montador_jogada_16.sv
// tb_montador_jogada_16: directed and random stimulus checked against a press/release entry model
module tb_montador_jogada_16;
`ifdef MONTADOR_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 5000;
`endif
  logic clock = 1'b0;
  logic clear, iniciar;
  logic [3:0] botoes;
  logic [15:0] dado;
  logic registra, ocupado, timeout;
  logic [1:0] digito;
  montador_jogada_16 #(.TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .clear   (clear),
    .iniciar (iniciar),
    .botoes  (botoes),
    .dado    (dado),
    .registra(registra),
    .ocupado (ocupado),
    .digito  (digito),
    .timeout (timeout)
  );
  always #5 clock = ~clock;
  int errors = 0, checks = 0;
  bit m_busy = 0, m_armed = 0, m_done = 0, m_tmo = 0;
  int m_q[$];
  int m_idle = 0;
  logic [15:0] m_word = '0;
  logic [15:0] downstream = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // Entry model: an entry is a list of nibbles; a press counts only when armed (keys released since last capture)
  task automatic model(input logic cl, input logic ini, input logic [3:0] b);
    m_tmo = 0;
    if (cl) begin
      m_busy = 0; m_done = 0; m_q = {}; m_word = '0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (ini) begin
        m_busy = 1; m_armed = 1; m_idle = 0; m_q = {}; m_word = '0;
      end
    end else if (m_armed) begin
      if (b != 4'd0) begin
        m_q.push_back(int'(b));
        m_word = {m_word[11:0], b};
        m_armed = 0;
      end
`ifdef MONTADOR_TIMEOUT_EN
      else if (m_idle == TO - 1) begin
        m_busy = 0; m_word = '0; m_q = {}; m_tmo = 1;
      end else m_idle++;
`endif
    end else if (b == 4'd0) begin
      if (m_q.size() == 4) m_done = 1;
      else begin
        m_armed = 1; m_idle = 0;
      end
    end
  endtask
  task automatic step(input logic cl, input logic ini, input logic [3:0] b);
    clear = cl; iniciar = ini; botoes = b;
    if (registra) downstream = dado;
    @(posedge clock);
    model(cl, ini, b);
    #1;
    check("dado", 32'(dado), 32'(m_word));
    check("registra", 32'(registra), 32'(m_done));
    check("ocupado", 32'(ocupado), 32'(m_busy));
    check("digito", 32'(digito), 32'(m_q.size() % 4));
    check("timeout", 32'(timeout), 32'(m_tmo));
  endtask
  task automatic digit(input logic [3:0] n, input int hold, input int gap, input logic ini);
    repeat (hold) step(0, ini, n);
    repeat (gap) step(0, 0, 4'd0);
  endtask
  initial begin
    int hold;
    logic [3:0] cur;
    clear = 1; iniciar = 0; botoes = 0;
    step(1, 0, 0);
    step(1, 1, 0);
    check("reset_dado", 32'(dado), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);
    // normal entry
    step(0, 1, 0);
    digit(4'h1, 3, 2, 0);
    digit(4'h2, 3, 2, 0);
    digit(4'h4, 3, 2, 0);
    digit(4'h8, 3, 1, 0);
    check("conclui_registra", 32'(registra), 32'h1);
    step(0, 0, 0);
    step(0, 0, 0);
    check("downstream", 32'(downstream), 32'h1248);
    check("dado_estavel", 32'(dado), 32'h1248);
    // clear mid-entry after two digits
    step(0, 1, 0);
    digit(4'h3, 2, 1, 0);
    digit(4'h5, 2, 1, 0);
    step(1, 0, 0);
    check("clear_ocupado", 32'(ocupado), 32'h0);
    check("clear_dado", 32'(dado), 32'h0);
    check("clear_registra", 32'(registra), 32'h0);
    // held key with a second key pulsed on top
    step(0, 1, 0);
    digit(4'h2, 8, 0, 0);
    digit(4'hA, 3, 0, 0);
    digit(4'h2, 9, 2, 0);
    check("held_digito", 32'(digito), 32'h1);
    check("held_dado", 32'(dado), 32'h0002);
    digit(4'h7, 1, 1, 1);
    digit(4'hF, 2, 1, 1);
    digit(4'h9, 2, 1, 1);
    check("restart_registra", 32'(registra), 32'h1);
    step(0, 1, 0);
    check("restart_ocupado", 32'(ocupado), 32'h0);
    check("restart_dado", 32'(dado), 32'h27F9);
    step(0, 0, 0);
`ifdef MONTADOR_TIMEOUT_EN
    step(0, 1, 0);
    digit(4'h3, 2, 15, 0);
    check("tmo_dado", 32'(dado), 32'h0);
    step(0, 1, 0);
    repeat (TO - 1) step(0, 0, 0);
    step(0, 0, 4'h4);
    check("tie_digito", 32'(digito), 32'h1);
    check("tie_timeout", 32'(timeout), 32'h0);
    step(1, 0, 0);
`endif
    hold = 0;
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        cur = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 4);
      end
      hold--;
      step($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, cur);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
